axis_debug_stream_select: RTL and testbench
===========================================

// Module: axis_debug_stream_select
// PURPOSE
//  Frame-aligned AXI4-Stream selector for the stereovision debug output. It picks one of
//  NUM_STREAMS pipeline taps (RGB input, gray, left/right unfolded, later disparity) with
//  switch_img and expands gray taps to RGB. Switching happens only at frame boundaries.
//  It supports full tready backpressure and feeds the display/VDMA path.
// PARAMETERS
//  NUM_STREAMS       4     number of input taps
//  SAMPLES_PER_CLOCK 4     pixels per beat
//  DATA_WIDTH        8     bits per colour channel
//  HEIGHT            2160  lines per frame; used to detect end of frame
//  SEL_WIDTH         4     width of switch_img
//  GRAY_MASK         4'b1110  bit i=1: tap i is gray, in the low SPC*DW bits
// PORTS
//  aclk               in   1              clock
//  aresetn            in   1              async active-low reset
//  s_axis_tdata       in   NS*3*SPC*DW    tap i at slice [i*3*SPC*DW +: 3*SPC*DW]
//  s_axis_tvalid      in   NS             per-tap valid
//  s_axis_tuser       in   NS             per-tap start of frame
//  s_axis_tlast       in   NS             per-tap end of line
//  s_axis_tready      out  NS             per-tap ready
//  m_axis_disp_tdata  out  3*SPC*DW       selected tap, RGB
//  m_axis_disp_tvalid out  1              output valid
//  m_axis_disp_tuser  out  1              output start of frame
//  m_axis_disp_tlast  out  1              output end of line
//  m_axis_disp_tready in   1              downstream ready
//  switch_img         in   SEL_WIDTH      requested tap, asynchronous (GPIO/switch)
//  active_sel         out  SEL_WIDTH      tap currently forwarded
//  switch_pending     out  1              request differs from active_sel
// BEHAVIOUR
//  - Reset: all m_axis_* = 0, active_sel = 0, switch_pending = 0, state WAIT_SOF,
//    line_cnt = 0, skid buffer empty.
//  - switch_img passes through a 2-FF synchroniser. The request (req) updates only after
//    the synchronised value is stable for 4 cycles. A value >= NUM_STREAMS maps to 0.
//  - Unselected taps: s_axis_tready = 1 (taps are discarded; upstream never stalls).
//  - Selected tap: s_axis_tready = skid buffer ready.
//  - Beat accepted = tvalid & tready on the selected tap.
//  - FSM:
//    WAIT_SOF: drop accepted beats until one has tuser=1. That beat is forwarded -> PASS.
//    PASS: forward all beats. line_cnt counts accepted tlast and resets to 0 on a
//      tuser beat. If req != active_sel -> DRAIN.
//    DRAIN: keep forwarding until the beat with tlast where line_cnt == HEIGHT-1 is
//      accepted. Then active_sel <= req and go to WAIT_SOF.
//    If req returns to active_sel during DRAIN, go back to PASS. The frame is not cut.
//  - A tuser beat that arrives during DRAIN ends the frame early (short frame): on that
//    beat active_sel <= req, then go to WAIT_SOF. The beat is dropped.
//  - Gray tap: each sample k is replicated into channels 0, 1 and 2 of pixel k.
//    RGB tap: passed unchanged.
//  - Output: 2-entry skid buffer with registered outputs. Latency is 1 cycle. Throughput
//    is 1 beat/cycle under continuous tready. Data, tuser and tlast stay stable while
//    tvalid=1 and tready=0.
//  - Reset mid-frame: output drops at once (tvalid=0) and the FSM restarts in WAIT_SOF
//    on the current req.
// STRUCTURE
//  - stereo_pkg: sel_state_t enum {WAIT_SOF, PASS, DRAIN}, function gray_to_rgb(), and
//    localparams for beat widths.
//  - Sub-module axis_skid_buffer #(WIDTH): the generic 2-entry register slice, carrying
//    tdata, tuser and tlast.
//  - Top level holds: synchroniser, debounce, FSM, line counter, tap mux.
// TESTING
//  1. Reset then switch_img=0. RGB frames of 4 lines (HEIGHT=4), beat data = beat index.
//     -> The first output beat is the SOF, data matches, latency 1, no gaps.
//  2. Select 1 (gray) with tap1 data 32'h04030201. -> Output tdata = 96'h040404_030303_
//     020202_010101. Tap0 tready stays 1.
//  3. Change switch_img 0->2 at line 1 of frame N. -> Tap0 is output to the end of
//     frame N (4 tlast). Tap2 output starts at its next tuser. No partial frame.
//  4. Random m_axis_disp_tready at 50%. -> Beat sequence equals the input, with no loss
//     or duplication, and data is stable while stalled.
//  5. switch_img=7 -> treated as 0. Glitch 0->3->0 lasting 2 cycles -> req unchanged,
//     switch_pending stays 0.
//  6. Assert aresetn low mid-line during PASS. -> Outputs go to 0 immediately. After
//     release, output resumes only at the next tuser.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared types and beat geometry for the stereovision debug stream selector.
// Gray taps carry one sample per pixel in the low bits of the beat.
package stereo_pkg;

  localparam int unsigned SPC    = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned PIX_W  = 3 * DW;
  localparam int unsigned BEAT_W = SPC * PIX_W;

  typedef enum logic [1:0] {
    WAIT_SOF,
    PASS,
    DRAIN
  } sel_state_t;

  // Copy gray sample k into all three colour channels of pixel k.
  function automatic logic [BEAT_W-1:0] gray_to_rgb(input logic [BEAT_W-1:0] beat);
    logic [BEAT_W-1:0] rgb;
    rgb = '0;
    for (int k = 0; k < int'(SPC); k++) begin
      for (int c = 0; c < 3; c++) begin
        rgb[k*PIX_W + c*DW +: DW] = beat[k*DW +: DW];
      end
    end
    return rgb;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream register slice with registered outputs.
// Upstream ready comes straight from a flop so no combinational path crosses the slice.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (i_ready || !r_out_valid) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= i_valid;
        if (i_valid) begin
          r_out_data <= i_data;
        end
      end
    end else if (i_valid && !r_skid_valid) begin
      // Output stalled: park the beat accepted on the strength of last cycle's ready.
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end

  assign o_ready = !r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/axis_debug_stream_select.sv
// Frame-aligned selector of one debug tap onto the display stream; gray taps become RGB.
// Tap switches only take effect between frames, so the display never sees a partial frame.
module axis_debug_stream_select
  import stereo_pkg::*;
#(
  parameter int unsigned            NUM_STREAMS       = 4,
  parameter int unsigned            SAMPLES_PER_CLOCK = SPC,
  parameter int unsigned            DATA_WIDTH        = DW,
  parameter int unsigned            HEIGHT            = 2160,
  parameter int unsigned            SEL_WIDTH         = 4,
  parameter logic [NUM_STREAMS-1:0] GRAY_MASK         = 4'b1110
) (
  input  logic                                                aclk,
  input  logic                                                aresetn,
  input  logic [NUM_STREAMS*3*SAMPLES_PER_CLOCK*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_STREAMS-1:0]                              s_axis_tvalid,
  input  logic [NUM_STREAMS-1:0]                              s_axis_tuser,
  input  logic [NUM_STREAMS-1:0]                              s_axis_tlast,
  output logic [NUM_STREAMS-1:0]                              s_axis_tready,
  output logic [3*SAMPLES_PER_CLOCK*DATA_WIDTH-1:0]           m_axis_disp_tdata,
  output logic                                                m_axis_disp_tvalid,
  output logic                                                m_axis_disp_tuser,
  output logic                                                m_axis_disp_tlast,
  input  logic                                                m_axis_disp_tready,
  input  logic [SEL_WIDTH-1:0]                                switch_img,
  output logic [SEL_WIDTH-1:0]                                active_sel,
  output logic                                                switch_pending
);

  localparam int unsigned BW = 3 * SAMPLES_PER_CLOCK * DATA_WIDTH;
  localparam int unsigned LW = $clog2(HEIGHT + 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);
  localparam logic [LW-1:0] LINES_MAX = LW'(HEIGHT);

  logic [SEL_WIDTH-1:0] r_sw_meta, r_sw_sync, r_sw_cand, r_req, r_active_sel, w_sel_nxt;
  logic [1:0]           r_stab_cnt;
  logic [LW-1:0]        r_line_cnt, w_line_nxt;
  sel_state_t           r_state, w_state_nxt;

  logic [BW-1:0] w_tap_data, w_beat_rgb, w_out_data;
  logic          w_tap_valid, w_tap_user, w_tap_last, w_tap_gray;
  logic          w_skid_ready, w_accept, w_eof, w_fwd;

  // Switch input: 2-FF synchroniser, then a 4-cycle stability filter before req moves.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_sw_cand  <= '0;
      r_stab_cnt <= '0;
      r_req      <= '0;
    end else begin
      r_sw_meta <= switch_img;
      r_sw_sync <= r_sw_meta;
      if (r_sw_sync != r_sw_cand) begin
        r_sw_cand  <= r_sw_sync;
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != 2'd3) begin
        r_stab_cnt <= r_stab_cnt + 2'd1;
      end else begin
        r_req <= (32'(r_sw_cand) < NUM_STREAMS) ? r_sw_cand : '0;
      end
    end
  end

  always_comb begin
    w_tap_data  = '0;
    w_tap_valid = 1'b0;
    w_tap_user  = 1'b0;
    w_tap_last  = 1'b0;
    w_tap_gray  = 1'b0;
    for (int i = 0; i < int'(NUM_STREAMS); i++) begin
      s_axis_tready[i] = 1'b1;
      if (r_active_sel == SEL_WIDTH'(i)) begin
        w_tap_data       = s_axis_tdata[i*BW +: BW];
        w_tap_valid      = s_axis_tvalid[i];
        w_tap_user       = s_axis_tuser[i];
        w_tap_last       = s_axis_tlast[i];
        w_tap_gray       = GRAY_MASK[i];
        s_axis_tready[i] = w_skid_ready;
      end
    end
  end

  assign w_beat_rgb = w_tap_gray ? gray_to_rgb(w_tap_data) : w_tap_data;
  assign w_accept   = w_tap_valid & w_skid_ready;
  assign w_eof      = w_tap_last & (r_line_cnt == LAST_LINE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= WAIT_SOF;
      r_line_cnt   <= '0;
      r_active_sel <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_line_cnt   <= w_line_nxt;
      r_active_sel <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_active_sel;
    w_line_nxt  = r_line_cnt;
    w_fwd       = 1'b0;
    unique case (r_state)
      WAIT_SOF: begin
        // No frame in flight, so a new request can be taken immediately.
        if (r_req != r_active_sel) begin
          w_sel_nxt = r_req;
        end else if (w_accept && w_tap_user) begin
          w_fwd       = 1'b1;
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        w_fwd = w_accept;
        if (r_req != r_active_sel) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_accept && w_tap_user) begin
          // Short frame: the new frame's SOF closes this one and is dropped.
          w_sel_nxt   = r_req;
          w_state_nxt = WAIT_SOF;
        end else if (w_accept && w_eof) begin
          w_fwd       = 1'b1;
          w_sel_nxt   = r_req;
          w_state_nxt = WAIT_SOF;
        end else begin
          w_fwd = w_accept;
          if (r_req == r_active_sel) w_state_nxt = PASS;
        end
      end
      default: w_state_nxt = WAIT_SOF;
    endcase
    if (w_fwd) begin
      if (w_tap_user) begin
        w_line_nxt = w_tap_last ? LW'(1) : '0;
      end else if (w_tap_last && r_line_cnt != LINES_MAX) begin
        w_line_nxt = r_line_cnt + LW'(1);
      end
    end
  end

  axis_skid_buffer #(
    .WIDTH(BW + 2)
  ) u_skid (
    .i_clk  (aclk),
    .i_rst_n(aresetn),
    .i_valid(w_fwd),
    .o_ready(w_skid_ready),
    .i_data ({w_beat_rgb, w_tap_user, w_tap_last}),
    .o_valid(m_axis_disp_tvalid),
    .i_ready(m_axis_disp_tready),
    .o_data ({w_out_data, m_axis_disp_tuser, m_axis_disp_tlast})
  );

  assign m_axis_disp_tdata = w_out_data;
  assign active_sel        = r_active_sel;
  assign switch_pending    = (r_req != r_active_sel);

endmodule

// File: tb/tb_axis_debug_stream_select.sv
// Bench for axis_debug_stream_select: directed table of single frames plus random traffic
// whose beats self-identify (tap, frame, beat) so every output beat can be predicted.
module tb_axis_debug_stream_select;

  localparam int NS = 4;
  localparam int BW = 96;
  localparam int SW = 4;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NS*BW-1:0] s_tdata = '0;
  logic [NS-1:0]    s_tvalid = '0, s_tuser = '0, s_tlast = '0, s_tready;
  logic [BW-1:0]    m_tdata;
  logic             m_tvalid, m_tuser, m_tlast;
  logic             m_tready = 1'b1;
  logic [SW-1:0]    switch_img = '0, active_sel;
  logic             switch_pending;

  always #5 aclk = ~aclk;

  axis_debug_stream_select #(
    .NUM_STREAMS(4), .SAMPLES_PER_CLOCK(4), .DATA_WIDTH(8), .HEIGHT(4), .SEL_WIDTH(4),
    .GRAY_MASK(4'b1110)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_disp_tdata(m_tdata), .m_axis_disp_tvalid(m_tvalid),
    .m_axis_disp_tuser(m_tuser), .m_axis_disp_tlast(m_tlast),
    .m_axis_disp_tready(m_tready),
    .switch_img(switch_img), .active_sel(active_sel), .switch_pending(switch_pending)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference beat contents: tap 0 is RGB, taps 1..3 are gray in the low 32 bits.
  function automatic logic [95:0] raw_rgb(input int f, input int b);
    logic [95:0] d;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) d[8*k +: 8] = 8'(b);
      else if (k == 3) d[8*k +: 8] = 8'(f);
      else if (k == 6) d[8*k +: 8] = 8'h00;
      else if (k == 9) d[8*k +: 8] = 8'hA5;
      else d[8*k +: 8] = 8'((b * 7 + f * 13 + k * 29) % 256);
    end
    return d;
  endfunction

  function automatic logic [31:0] gray_raw(input int t, input int f, input int b);
    return {8'hA5, 8'(t), 8'(f), 8'(b)};
  endfunction

  function automatic logic [95:0] expand(input logic [31:0] g);
    logic [95:0] d;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) d[24*k + 8*c +: 8] = g[8*k +: 8];
    end
    return d;
  endfunction

  function automatic logic [95:0] exp_beat(input int t, input int f, input int b);
    return (t == 0) ? raw_rgb(f, b) : expand(gray_raw(t, f, b));
  endfunction

  // Free-running source state and output scoreboard.
  int          g_frame[NS];
  int          g_beat[NS];
  logic [NS-1:0] hs;
  bit          gen_en = 0, chk_en = 0, unsel_chk = 0;
  bit          in_frame = 0, prev_stall = 0;
  int          cur_t, cur_f, cur_b;
  logic [97:0] held;
  int          frame_taps[$];
  int          last_done_tap = -1;

  task automatic drive_tap(input int t);
    if (t == 0) s_tdata[t*BW +: BW] = raw_rgb(g_frame[t], g_beat[t]);
    else s_tdata[t*BW +: BW] = {$urandom, $urandom, gray_raw(t, g_frame[t], g_beat[t])};
    s_tuser[t] = (g_beat[t] == 0);
    s_tlast[t] = (g_beat[t] % 4 == 3);
  endtask

  task automatic step();
    int t, f, b;
    @(negedge aclk);
    if (!aresetn) begin
      in_frame   = 0;
      prev_stall = 0;
    end else if (chk_en) begin
      if (unsel_chk) chk("unsel_ready", s_tready[3:1], 3'b111);
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, held});
      if (m_tvalid && m_tready) begin
        t = int'(m_tdata[55:48]);
        f = int'(m_tdata[31:24]);
        b = int'(m_tdata[7:0]);
        chk("beat_data", m_tdata, exp_beat(t % NS, f, b));
        chk("beat_flags", {m_tuser, m_tlast}, {b == 0, b % 4 == 3});
        if (!in_frame) chk("frame_start", b, 0);
        else chk("frame_cont", t * 65536 + f * 256 + b, cur_t * 65536 + cur_f * 256 + cur_b + 1);
        if (b == 0) frame_taps.push_back(t);
        if (b == 15) last_done_tap = t;
        in_frame = (b != 15);
        cur_t = t;
        cur_f = f;
        cur_b = b;
      end
      prev_stall = m_tvalid && !m_tready;
      held = {m_tuser, m_tlast, m_tdata};
    end
    hs = s_tvalid & s_tready;
    @(posedge aclk);
    #1;
    if (gen_en) begin
      for (int i = 0; i < NS; i++) begin
        if (hs[i]) begin
          g_beat[i] = (g_beat[i] + 1) % 16;
          if (g_beat[i] == 0) g_frame[i] = (g_frame[i] + 1) % 256;
        end
        if (!s_tvalid[i] || hs[i]) begin
          s_tvalid[i] = ($urandom_range(0, 4) != 0);
          drive_tap(i);
        end
      end
      m_tready = 1'($urandom_range(0, 1));
    end
  endtask

  typedef struct {
    logic [3:0]  sel;
    int          src;
    logic [3:0]  exp_sel;
    bit          exp_valid;
    logic [95:0] din;
    logic [95:0] dout;
  } rec_t;

  rec_t recs[7];

  task automatic run_rec(input rec_t r);
    aresetn  = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b1;
    switch_img = r.sel;
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_state", {m_tvalid, m_tuser, m_tlast, m_tdata, active_sel, switch_pending}, '0);
    aresetn = 1'b1;
    repeat (12) @(posedge aclk);
    #1;
    chk("rec_active_sel", active_sel, r.exp_sel);
    chk("rec_pending", switch_pending, 1'b0);
    s_tdata[r.src*BW +: BW] = r.din;
    s_tvalid[r.src] = 1'b1;
    s_tuser[r.src]  = 1'b1;
    s_tlast[r.src]  = 1'b1;
    @(negedge aclk);
    chk("rec_latency", m_tvalid, 1'b0);
    chk("rec_tready", s_tready, 4'hF);
    for (int k = 0; k < 4; k++) begin
      @(posedge aclk);
      #1;
      if (k < 3) s_tuser[r.src] = 1'b0;
      else s_tvalid[r.src] = 1'b0;
      @(negedge aclk);
      if (r.exp_valid)
        chk("rec_out", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, k == 0, 1'b1, r.dout});
      else chk("rec_drop", m_tvalid, 1'b0);
    end
  endtask

  initial begin
    bit found;
    int n0, sw;
    recs[0] = '{4'd0, 0, 4'd0, 1'b1, 96'h0123456789abcdef_fedcba98, 96'h0123456789abcdef_fedcba98};
    recs[1] = '{4'd1, 1, 4'd1, 1'b1, {64'hdeadbeef_cafef00d, 32'h04030201},
                96'h040404_030303_020202_010101};
    recs[2] = '{4'd2, 2, 4'd2, 1'b1, {64'h1111_2222_3333_4444, 32'hff00a55a},
                96'hffffff_000000_a5a5a5_5a5a5a};
    recs[3] = '{4'd3, 3, 4'd3, 1'b1, {64'h0, 32'h807f01fe}, 96'h808080_7f7f7f_010101_fefefe};
    recs[4] = '{4'd2, 1, 4'd2, 1'b0, 96'h0000_0000_0000_0000_1234_5678, 96'h0};
    recs[5] = '{4'd7, 0, 4'd0, 1'b1, 96'h0a0b0c0d_0e0f1011_12131415, 96'h0a0b0c0d_0e0f1011_12131415};
    recs[6] = '{4'd5, 0, 4'd0, 1'b1, 96'h55aa55aa_00ff00ff_c3c3c3c3, 96'h55aa55aa_00ff00ff_c3c3c3c3};
    for (int i = 0; i < 7; i++) run_rec(recs[i]);

    // Two-cycle glitch on the switch must not move the request.
    switch_img = 4'd3;
    step();
    step();
    switch_img = 4'd0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("glitch_pending", switch_pending, 1'b0);
    end
    chk("glitch_sel", active_sel, 4'd0);
    // A stable request is seen, but the current frame is never cut.
    switch_img = 4'd3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = switch_pending;
    end
    chk("debounce_pending", found, 1'b1);
    step();
    step();
    chk("drain_holds_sel", active_sel, 4'd0);
    // A new SOF during drain closes the frame early and is itself dropped.
    s_tvalid[0] = 1'b1;
    s_tuser[0]  = 1'b1;
    s_tlast[0]  = 1'b0;
    @(posedge aclk);
    #1;
    s_tvalid[0] = 1'b0;
    @(negedge aclk);
    chk("short_frame_drop", m_tvalid, 1'b0);
    chk("short_frame_sel", {active_sel, switch_pending}, {4'd3, 1'b0});

    // Random traffic with 50% output backpressure.
    aresetn = 1'b0;
    switch_img = 4'd0;
    for (int i = 0; i < NS; i++) begin
      g_frame[i] = i * 50;
      g_beat[i] = $urandom_range(0, 15);
      drive_tap(i);
    end
    s_tvalid = '0;
    gen_en = 1;
    chk_en = 1;
    step();
    step();
    aresetn = 1'b1;
    unsel_chk = 1;
    for (int i = 0; i < 300; i++) step();
    unsel_chk = 0;
    chk("phaseA_frames", frame_taps.size() >= 2, 1'b1);
    chk("phaseA_tap", last_done_tap, 0);

    // Switch to tap 2 at line 1 of a tap-0 frame.
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      found = in_frame && cur_t == 0 && cur_b == 4;
    end
    chk("reach_line1", found, 1'b1);
    switch_img = 4'd2;
    n0 = frame_taps.size();
    for (int i = 0; i < 1000 && frame_taps.size() <= n0; i++) step();
    chk("switch_started", frame_taps.size() > n0, 1'b1);
    if (frame_taps.size() > n0) chk("switch_new_tap", frame_taps[n0], 2);

    // Reset mid-line while passing.
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      found = in_frame && (cur_b % 4 == 1);
    end
    chk("reach_midline", found, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("reset_async_out", {m_tvalid, m_tuser, m_tlast, m_tdata, active_sel}, '0);
    repeat (3) step();
    aresetn = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("after_reset_tap", last_done_tap, 2);

    // Random stable selections, including out-of-range codes.
    for (int j = 0; j < 6; j++) begin
      sw = $urandom_range(0, 7);
      switch_img = 4'(sw);
      for (int i = 0; i < 300; i++) step();
      chk("stable_frame_tap", last_done_tap, (sw < NS) ? sw : 0);
      chk("stable_active_sel", active_sel, (sw < NS) ? sw : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
